// File: rtl/decryption_dispatcher.sv
// Shares one upstream character stream among several decryption engines: latches the engine
// on the first char of a message, forwards the message, then muxes that engine's output back.
module decryption_dispatcher #(
  parameter int                 D_WIDTH                = 8,
  parameter int                 NOF_ENGINES            = 3,
  parameter int                 SEL_WIDTH              = 2,
  parameter int                 MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(8'hFA),
  parameter int                 BUSY_TIMEOUT           = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [D_WIDTH-1:0]             data_i,
  input  logic                           valid_i,
  input  logic [SEL_WIDTH-1:0]           sel_i,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [D_WIDTH-1:0]             eng_data_o,
  output logic [NOF_ENGINES-1:0]         eng_valid_o,
  input  logic [NOF_ENGINES-1:0]         eng_busy_i,
  input  logic [NOF_ENGINES*D_WIDTH-1:0] eng_data_i,
  input  logic [NOF_ENGINES-1:0]         eng_valid_i,
  output logic [D_WIDTH-1:0]             data_o,
  output logic                           valid_o
);

  localparam int CNT_W = $clog2(MAX_NOF_CHARS + 1);
  localparam int TMR_W = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_NOF_CHARS);
  localparam logic [TMR_W-1:0]   TMR_MAX = TMR_W'(BUSY_TIMEOUT);
  localparam logic [SEL_WIDTH:0] NOF_ENG = (SEL_WIDTH + 1)'(NOF_ENGINES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_RUN
  } state_t;

  state_t               state, state_d;
  logic [SEL_WIDTH-1:0] cur_sel, cur_sel_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [TMR_W-1:0]     timer, timer_d;

  logic                   tok_p0;
  logic                   fwd_vld_p0;
  logic [NOF_ENGINES-1:0] fwd_oh_p0;
  logic                   err_p0;
  logic                   busy_p0;
  logic                   sel_busy_p0;
  logic                   sel_vld_p0;
  logic [D_WIDTH-1:0]     sel_data_p0;
  logic                   ret_vld_p0;
  logic [D_WIDTH-1:0]     ret_data_p0;

  // Saturating timer increment: holds at the timeout value instead of wrapping.
  function automatic logic [TMR_W-1:0] sat_inc_tmr(input logic [TMR_W-1:0] t);
    if (t >= TMR_MAX) begin
      return TMR_MAX;
    end
    return t + TMR_W'(1);
  endfunction

  // Count of chars stored so far, clipped to the engine buffer depth.
  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] c);
    if (c >= CNT_MAX) begin
      return CNT_MAX;
    end
    return c + CNT_W'(1);
  endfunction

  // Stage p0: pick the latched engine's handshake and return data.
  always_comb begin
    sel_busy_p0 = 1'b0;
    sel_vld_p0  = 1'b0;
    sel_data_p0 = '0;
    for (int k = 0; k < NOF_ENGINES; k++) begin
      if (cur_sel == SEL_WIDTH'(k)) begin
        sel_busy_p0 = eng_busy_i[k];
        sel_vld_p0  = eng_valid_i[k];
        sel_data_p0 = eng_data_i[k*D_WIDTH +: D_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state;
    cur_sel_d  = cur_sel;
    cnt_d      = cnt;
    timer_d    = '0;
    fwd_vld_p0 = 1'b0;
    err_p0     = 1'b0;
    tok_p0     = (data_i == START_DECRYPTION_TOKEN);

    case (state)
      S_IDLE: begin
        if (valid_i) begin
          if ({1'b0, sel_i} >= NOF_ENG) begin
            err_p0 = 1'b1;
          end else begin
            cur_sel_d  = sel_i;
            fwd_vld_p0 = 1'b1;
            if (tok_p0) begin
              state_d = S_WAIT;
            end else begin
              cnt_d   = CNT_W'(1);
              state_d = S_LOAD;
            end
          end
        end
      end

      S_LOAD: begin
        if (valid_i) begin
          if (tok_p0) begin
            fwd_vld_p0 = 1'b1;
            state_d    = S_WAIT;
          end else if (cnt < CNT_MAX) begin
            fwd_vld_p0 = 1'b1;
            cnt_d      = sat_inc_cnt(cnt);
          end else begin
            err_p0 = 1'b1;
          end
        end
      end

      S_WAIT: begin
        err_p0 = valid_i;
        if (sel_busy_p0) begin
          state_d = S_RUN;
        end else if (timer >= TMR_MAX) begin
          err_p0  = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d = sat_inc_tmr(timer);
        end
      end

      S_RUN: begin
        err_p0 = valid_i;
        if (!sel_busy_p0) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    fwd_oh_p0 = '0;
    for (int k = 0; k < NOF_ENGINES; k++) begin
      if (cur_sel_d == SEL_WIDTH'(k)) begin
        fwd_oh_p0[k] = fwd_vld_p0;
      end
    end
  end

  // Return path only listens while the engine is running; output is zeroed when not valid.
  assign ret_vld_p0  = (state == S_RUN) && sel_vld_p0;
  assign ret_data_p0 = ret_vld_p0 ? sel_data_p0 : '0;
  assign busy_p0     = (state_d == S_WAIT) || (state_d == S_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cur_sel <= '0;
      cnt     <= '0;
      timer   <= '0;
    end else begin
      state   <= state_d;
      cur_sel <= cur_sel_d;
      cnt     <= cnt_d;
      timer   <= timer_d;
    end
  end

  // Stage p1: registered outputs, one cycle after the decision in p0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      eng_data_o  <= '0;
      eng_valid_o <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
    end else begin
      busy_o      <= busy_p0;
      err_o       <= err_p0;
      eng_valid_o <= fwd_oh_p0;
      if (fwd_vld_p0) begin
        eng_data_o <= data_i;
      end
      data_o      <= ret_data_p0;
      valid_o     <= ret_vld_p0;
    end
  end

endmodule

// File: tb/tb_decryption_dispatcher.sv
// Bench for decryption_dispatcher: vector table for a full message round-trip plus hand
// sequences for buffer overflow, busy timeout and mid-run reset, with queue-based scoreboards.
module tb_decryption_dispatcher;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        valid_i;
  logic [1:0]  sel_i;
  logic        busy_o;
  logic        err_o;
  logic [7:0]  eng_data_o;
  logic [2:0]  eng_valid_o;
  logic [2:0]  eng_busy_i;
  logic [23:0] eng_data_i;
  logic [2:0]  eng_valid_i;
  logic [7:0]  data_o;
  logic        valid_o;

  int checks = 0;
  int errors = 0;

  logic [10:0] fwd_q[$];
  logic [7:0]  ret_q[$];

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [2:0]  ebusy;
    logic [2:0]  evld;
    logic [23:0] edata;
    logic [2:0]  fwd_oh;
    logic        ret;
    logic [7:0]  ret_data;
    logic        err;
    logic        busy;
  } vec_t;

  vec_t tbl[15];

  decryption_dispatcher dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .sel_i      (sel_i),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .eng_data_o (eng_data_o),
    .eng_valid_o(eng_valid_o),
    .eng_busy_i (eng_busy_i),
    .eng_data_i (eng_data_i),
    .eng_valid_i(eng_valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock edge, then compare both datapaths against whatever was queued before the edge.
  task automatic tick();
    logic [2:0] exp_oh;
    logic [7:0] exp_d;
    logic       exp_rv;
    logic [7:0] exp_rd;
    @(posedge clk);
    #1;
    exp_oh = 3'b000;
    exp_d  = 8'h00;
    if (fwd_q.size() > 0) {exp_oh, exp_d} = fwd_q.pop_front();
    chk("eng_valid_o", 32'(eng_valid_o), 32'(exp_oh));
    if (exp_oh != 3'b000) chk("eng_data_o", 32'(eng_data_o), 32'(exp_d));
    exp_rv = 1'b0;
    exp_rd = 8'h00;
    if (ret_q.size() > 0) begin
      exp_rv = 1'b1;
      exp_rd = ret_q.pop_front();
    end
    chk("valid_o", 32'(valid_o), 32'(exp_rv));
    chk("data_o", 32'(data_o), 32'(exp_rd));
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic [2:0] exp_oh);
    valid_i = 1'b1;
    sel_i   = s;
    data_i  = d;
    if (exp_oh != 3'b000) fwd_q.push_back({exp_oh, d});
    tick();
    valid_i = 1'b0;
  endtask

  function automatic vec_t mk(input logic vld, input logic [1:0] sel, input logic [7:0] data,
                              input logic [2:0] ebusy, input logic [2:0] evld,
                              input logic [23:0] edata, input logic [2:0] fwd_oh,
                              input logic ret, input logic [7:0] ret_data,
                              input logic err, input logic busy);
    vec_t v;
    v.vld = vld; v.sel = sel; v.data = data; v.ebusy = ebusy; v.evld = evld;
    v.edata = edata; v.fwd_oh = fwd_oh; v.ret = ret; v.ret_data = ret_data;
    v.err = err; v.busy = busy;
    return v;
  endfunction

  initial begin
    bit seen;

    //         vld sel data   ebusy   evld    edata       fwd_oh  ret ret_d  err busy
    tbl[0]  = mk(1, 3, 8'h11, 3'b000, 3'b000, 24'h000000, 3'b000, 0, 8'h00, 1, 0);
    tbl[1]  = mk(0, 0, 8'h00, 3'b000, 3'b000, 24'h000000, 3'b000, 0, 8'h00, 0, 0);
    tbl[2]  = mk(1, 1, 8'h41, 3'b000, 3'b000, 24'h000000, 3'b010, 0, 8'h00, 0, 0);
    tbl[3]  = mk(1, 2, 8'h42, 3'b000, 3'b000, 24'h000000, 3'b010, 0, 8'h00, 0, 0);
    tbl[4]  = mk(1, 0, 8'h43, 3'b000, 3'b000, 24'h000000, 3'b010, 0, 8'h00, 0, 0);
    tbl[5]  = mk(1, 3, 8'h44, 3'b000, 3'b000, 24'h000000, 3'b010, 0, 8'h00, 0, 0);
    tbl[6]  = mk(1, 1, 8'hFA, 3'b000, 3'b000, 24'h000000, 3'b010, 0, 8'h00, 0, 1);
    tbl[7]  = mk(0, 0, 8'h00, 3'b101, 3'b101, 24'h770077, 3'b000, 0, 8'h00, 0, 1);
    tbl[8]  = mk(0, 0, 8'h00, 3'b010, 3'b000, 24'h000000, 3'b000, 0, 8'h00, 0, 1);
    tbl[9]  = mk(0, 0, 8'h00, 3'b010, 3'b111, 24'h332211, 3'b000, 1, 8'h22, 0, 1);
    tbl[10] = mk(0, 0, 8'h00, 3'b010, 3'b101, 24'h665544, 3'b000, 0, 8'h00, 0, 1);
    tbl[11] = mk(1, 1, 8'h55, 3'b010, 3'b010, 24'h009900, 3'b000, 1, 8'h99, 1, 1);
    tbl[12] = mk(0, 0, 8'h00, 3'b111, 3'b111, 24'h113C11, 3'b000, 1, 8'h3C, 0, 1);
    tbl[13] = mk(0, 0, 8'h00, 3'b101, 3'b010, 24'h00A500, 3'b000, 1, 8'hA5, 0, 0);
    tbl[14] = mk(0, 0, 8'h00, 3'b000, 3'b010, 24'h007700, 3'b000, 0, 8'h00, 0, 0);

    // Reset with busy inputs everywhere: nothing may leak out.
    rst_n = 1'b0; valid_i = 1'b1; sel_i = 2'd1; data_i = 8'h41;
    eng_busy_i = 3'b111; eng_valid_i = 3'b111; eng_data_i = 24'hABCDEF;
    tick();
    tick();
    chk("reset busy_o", 32'(busy_o), 32'd0);
    chk("reset err_o", 32'(err_o), 32'd0);
    chk("reset eng_data_o", 32'(eng_data_o), 32'd0);
    rst_n = 1'b1; valid_i = 1'b0;
    eng_busy_i = 3'b000; eng_valid_i = 3'b000; eng_data_i = 24'h0;
    tick();

    // Bad select, full message to engine 1, run with echoed output, upstream char while busy.
    for (int i = 0; i < 15; i++) begin
      valid_i     = tbl[i].vld;
      sel_i       = tbl[i].sel;
      data_i      = tbl[i].data;
      eng_busy_i  = tbl[i].ebusy;
      eng_valid_i = tbl[i].evld;
      eng_data_i  = tbl[i].edata;
      if (tbl[i].fwd_oh != 3'b000) fwd_q.push_back({tbl[i].fwd_oh, tbl[i].data});
      if (tbl[i].ret) ret_q.push_back(tbl[i].ret_data);
      tick();
      chk($sformatf("vec%0d err_o", i), 32'(err_o), 32'(tbl[i].err));
      chk($sformatf("vec%0d busy_o", i), 32'(busy_o), 32'(tbl[i].busy));
    end
    valid_i = 1'b0; eng_busy_i = 3'b000; eng_valid_i = 3'b000; eng_data_i = 24'h0;
    tick();

    // Overflow: 50 chars fit the buffer, the 51st is dropped, the token still goes through.
    for (int i = 0; i < 51; i++) begin
      send(2'd0, 8'(i + 1), (i < 50) ? 3'b001 : 3'b000);
      chk($sformatf("load%0d err_o", i), 32'(err_o), (i == 50) ? 32'd1 : 32'd0);
      chk($sformatf("load%0d busy_o", i), 32'(busy_o), 32'd0);
    end
    send(2'd3, 8'hFA, 3'b001);
    chk("load token busy_o", 32'(busy_o), 32'd1);
    chk("load token err_o", 32'(err_o), 32'd0);

    // Engine 0 never answers; unrelated engines toggle busy. Timeout coincides with a stray char.
    for (int k = 1; k <= 6; k++) begin
      eng_busy_i = (k % 2 == 1) ? 3'b110 : 3'b010;
      valid_i    = (k == 5);
      data_i     = 8'h12;
      tick();
      chk($sformatf("timeout%0d err_o", k), 32'(err_o), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("timeout%0d busy_o", k), 32'(busy_o), (k < 5) ? 32'd1 : 32'd0);
    end
    valid_i = 1'b0; eng_busy_i = 3'b000;

    // Empty message to engine 2, reset while it runs, then a fresh message is accepted.
    send(2'd2, 8'hFA, 3'b100);
    chk("empty msg busy_o", 32'(busy_o), 32'd1);
    eng_busy_i = 3'b100;
    tick();
    eng_valid_i = 3'b100; eng_data_i = 24'hC30000;
    ret_q.push_back(8'hC3);
    tick();
    chk("run busy_o", 32'(busy_o), 32'd1);
    rst_n = 1'b0; valid_i = 1'b1; data_i = 8'h20;
    tick();
    chk("mid-run reset busy_o", 32'(busy_o), 32'd0);
    chk("mid-run reset err_o", 32'(err_o), 32'd0);
    rst_n = 1'b1; valid_i = 1'b0;
    tick();
    chk("after reset busy_o", 32'(busy_o), 32'd0);
    eng_busy_i = 3'b000; eng_valid_i = 3'b000; eng_data_i = 24'h0;
    send(2'd0, 8'h31, 3'b001);
    chk("after reset err_o", 32'(err_o), 32'd0);
    send(2'd1, 8'hFA, 3'b001);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (err_o) seen = 1'b1;
    end
    chk("timeout seen within bound", 32'(seen), 32'd1);
    chk("timeout returns idle", 32'(busy_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
